// File: rtl/divide_datapath.sv
// Restoring shift-subtract datapath for the unsigned divider: working divisor,
// remainder, quotient and shift count, driven by strobes from the divide control.
module divide_datapath #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    input  logic             init,
    input  logic             left,
    input  logic             right,
    input  logic             sub,
    output logic             cnt_is_0,
    output logic             divisor_is_0,
    output logic             dvsr_less_than_dvnd,
    output logic             shifted_divisor_MSB,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [CW-1:0]    c_q;

    // Strobe priority init > left > right; no strobe holds all state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q <= '0;
            r_q <= '0;
            q_q <= '0;
            c_q <= '0;
        end else if (init) begin
            d_q <= divisor_in;
            r_q <= dividend_in;
            q_q <= '0;
            c_q <= '0;
        end else if (left) begin
            // Normalise only while the divisor MSB is clear, so no bit is lost.
            if (!d_q[WIDTH-1]) begin
                d_q <= d_q << 1;
                c_q <= c_q + CW'(1);
            end
        end else if (right) begin
            if (sub) begin
                r_q <= r_q - d_q;
                q_q <= {q_q[WIDTH-2:0], 1'b1};
            end else begin
                q_q <= {q_q[WIDTH-2:0], 1'b0};
            end
            // Final step runs with count at zero; divisor is back at its original value.
            if (c_q != '0) begin
                d_q <= d_q >> 1;
                c_q <= c_q - CW'(1);
            end
        end
    end

    assign cnt_is_0            = (c_q == '0);
    assign divisor_is_0        = (divisor_in == '0);
    assign dvsr_less_than_dvnd = (d_q <= r_q);
    assign shifted_divisor_MSB = d_q[WIDTH-1];
    assign quotient            = q_q;
    assign remainder           = r_q;

endmodule
